// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer taking whole I-cache lines from the fetch PC onward and
// handing up to READ_WIDTH instructions per cycle to decode. Optional INSTQ_PERF_EN adds occupancy/stall counters.
module inst_fetch_queue #(
  parameter int DEPTH       = 32,
  parameter int WRITE_WIDTH = 16,
  parameter int READ_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      icache_valid_i,
  input  logic [63:0]               icache_pc_i,
  input  logic [32*WRITE_WIDTH-1:0] icache_data_i,
  output logic                      icache_ready_o,
  output logic [READ_WIDTH-1:0]     iq_vld_o,
  output logic [64*READ_WIDTH-1:0]  iq_pc_o,
  output logic [32*READ_WIDTH-1:0]  iq_inst_o,
  input  logic                      stall_iq_i,
  input  logic                      flush_iq_i
`ifdef INSTQ_PERF_EN
  ,
  output logic [$clog2(DEPTH):0]    instq_cnt_o,
  output logic [31:0]               full_cycles_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(WRITE_WIDTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WW_C    = CW'(WRITE_WIDTH);
  localparam logic [CW-1:0] RW_C    = CW'(READ_WIDTH);
  localparam logic [OW:0]   WW_N_C  = (OW+1)'(WRITE_WIDTH);

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [63:0]   pc_mem_q   [DEPTH];

  logic [CW-1:0] free_s, n_deq_s;
  logic [OW-1:0] off_s;
  logic [OW:0]   n_enq_s;
  logic          enq_s, deq_s;
  logic [63:0]   base_pc_s;
  logic [31:0]   wr_inst_s [WRITE_WIDTH];
  logic [63:0]   wr_pc_s   [WRITE_WIDTH];
  logic [WRITE_WIDTH-1:0] wr_en_s;
  logic          unused_pc_s;

  // A same-cycle dequeue is deliberately not credited, keeping ready off the stall path.
  assign free_s         = DEPTH_C - count_q;
  assign icache_ready_o = (free_s >= WW_C) && !flush_iq_i;
  assign enq_s          = icache_valid_i && icache_ready_o;
  assign deq_s          = !stall_iq_i && !flush_iq_i;
  assign off_s          = icache_pc_i[OW+1:2];
  assign n_enq_s        = WW_N_C - {1'b0, off_s};
  assign n_deq_s        = (count_q < RW_C) ? count_q : RW_C;
  assign base_pc_s      = {icache_pc_i[63:2], 2'b00};
  assign unused_pc_s    = ^icache_pc_i[1:0];

  for (genvar i = 0; i < WRITE_WIDTH; i++) begin : g_wr
    logic [OW-1:0] widx_s;
    assign widx_s       = off_s + OW'(i);
    assign wr_inst_s[i] = icache_data_i[32*widx_s +: 32];
    assign wr_pc_s[i]   = base_pc_s + 64'(4*i);
    assign wr_en_s[i]   = enq_s && ((OW+1)'(i) < n_enq_s);
  end

  // Next-state for pointers and occupancy; flush overrides any enqueue or dequeue.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_iq_i) begin
      rptr_d  = {AW{1'b0}};
      wptr_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (enq_s) begin
        wptr_d = wptr_q + AW'(n_enq_s);
      end else begin
        wptr_d = wptr_q;
      end
      if (deq_s) begin
        rptr_d = rptr_q + AW'(n_deq_s);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + (enq_s ? CW'(n_enq_s) : {CW{1'b0}}) - (deq_s ? n_deq_s : {CW{1'b0}});
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= {AW{1'b0}};
      wptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage has no reset; only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_WIDTH; i++) begin
      if (wr_en_s[i]) begin
        inst_mem_q[wptr_q + AW'(i)] <= wr_inst_s[i];
        pc_mem_q[wptr_q + AW'(i)]   <= wr_pc_s[i];
      end
    end
  end

  for (genvar j = 0; j < READ_WIDTH; j++) begin : g_rd
    assign iq_vld_o[j]           = count_q > CW'(j);
    assign iq_pc_o[64*j +: 64]   = pc_mem_q[rptr_q + AW'(j)];
    assign iq_inst_o[32*j +: 32] = inst_mem_q[rptr_q + AW'(j)];
  end

`ifdef INSTQ_PERF_EN
  logic [31:0] full_cycles_q;

  // Saturating count of cycles where a line was offered but refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cycles_q <= 32'd0;
    end else if (icache_valid_i && !icache_ready_o && (full_cycles_q != 32'hFFFF_FFFF)) begin
      full_cycles_q <= full_cycles_q + 32'd1;
    end else begin
      full_cycles_q <= full_cycles_q;
    end
  end

  assign instq_cnt_o   = count_q;
  assign full_cycles_o = full_cycles_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model. Perf-port checks are included when INSTQ_PERF_EN is defined.
module tb_inst_fetch_queue;
  localparam int DEPTH = 32;
  localparam int WW    = 16;
  localparam int RW    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              icache_valid_i;
  logic [63:0]       icache_pc_i;
  logic [32*WW-1:0]  icache_data_i;
  logic              icache_ready_o;
  logic [RW-1:0]     iq_vld_o;
  logic [64*RW-1:0]  iq_pc_o;
  logic [32*RW-1:0]  iq_inst_o;
  logic              stall_iq_i;
  logic              flush_iq_i;
`ifdef INSTQ_PERF_EN
  logic [$clog2(DEPTH):0] instq_cnt_o;
  logic [31:0]            full_cycles_o;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .WRITE_WIDTH(WW), .READ_WIDTH(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_valid_i (icache_valid_i),
    .icache_pc_i    (icache_pc_i),
    .icache_data_i  (icache_data_i),
    .icache_ready_o (icache_ready_o),
    .iq_vld_o       (iq_vld_o),
    .iq_pc_o        (iq_pc_o),
    .iq_inst_o      (iq_inst_o),
    .stall_iq_i     (stall_iq_i),
    .flush_iq_i     (flush_iq_i)
`ifdef INSTQ_PERF_EN
    ,
    .instq_cnt_o    (instq_cnt_o),
    .full_cycles_o  (full_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned full_exp = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    return ((DEPTH - q.size()) >= WW) && !flush_iq_i;
  endfunction

  task automatic check_outputs();
    logic [RW-1:0] vexp;
    check_val("ready", 64'(icache_ready_o), 64'(exp_ready()));
    for (int j = 0; j < RW; j++) vexp[j] = (q.size() > j);
    check_val("vld", 64'(iq_vld_o), 64'(vexp));
    for (int j = 0; j < RW; j++) begin
      if (j < q.size()) begin
        check_val($sformatf("pc%0d", j), iq_pc_o[64*j +: 64], q[j].pc);
        check_val($sformatf("inst%0d", j), 64'(iq_inst_o[32*j +: 32]), 64'(q[j].inst));
      end
    end
`ifdef INSTQ_PERF_EN
    check_val("cnt", 64'(instq_cnt_o), 64'(q.size()));
    check_val("full_cycles", 64'(full_cycles_o), 64'(full_exp));
`endif
  endtask

  // Reference behaviour at a rising edge: pops take the oldest entries, new words go to the back.
  task automatic model_step();
    logic rdy;
    int   off;
    int   npop;
    logic [63:0] base;
    rdy = exp_ready();
    if (icache_valid_i && !rdy) full_exp++;
    if (flush_iq_i) begin
      q.delete();
    end else begin
      if (!stall_iq_i) begin
        npop = (q.size() < RW) ? q.size() : RW;
        repeat (npop) void'(q.pop_front());
      end
      if (icache_valid_i && rdy) begin
        off  = int'(icache_pc_i[$clog2(WW)+1:2]);
        base = {icache_pc_i[63:2], 2'b00};
        for (int k = off; k < WW; k++)
          q.push_back({base + 64'(4*(k-off)), icache_data_i[32*k +: 32]});
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [63:0] pc, input logic st, input logic fl);
    icache_valid_i = v;
    icache_pc_i    = pc;
    stall_iq_i     = st;
    flush_iq_i     = fl;
    for (int k = 0; k < WW; k++) icache_data_i[32*k +: 32] = $urandom;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    icache_valid_i = 1'b0;
    icache_pc_i    = 64'd0;
    icache_data_i  = '0;
    stall_iq_i     = 1'b0;
    flush_iq_i     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    check_val("rst_vld", 64'(iq_vld_o), 64'd0);
    check_val("rst_ready", 64'(icache_ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned line, stalled backend
    cycle(1'b1, 64'h1000, 1'b1, 1'b0);
    check_val("al_vld", 64'(iq_vld_o), 64'h3);
    check_val("al_pc0", iq_pc_o[63:0], 64'h1000);
    check_val("al_pc1", iq_pc_o[127:64], 64'h1004);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b1);

    // Unaligned line: only words 14 and 15
    cycle(1'b1, 64'h1038, 1'b1, 1'b0);
    check_val("ua_vld", 64'(iq_vld_o), 64'h3);
    check_val("ua_pc0", iq_pc_o[63:0], 64'h1038);
    check_val("ua_pc1", iq_pc_o[127:64], 64'h103C);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_val("ua_empty", 64'(iq_vld_o), 64'd0);

    // Fill to DEPTH, then offered lines are refused
    cycle(1'b1, 64'h2000, 1'b1, 1'b0);
    cycle(1'b1, 64'h2040, 1'b1, 1'b0);
    check_val("full_ready", 64'(icache_ready_o), 64'd0);
    repeat (3) cycle(1'b1, 64'h3000, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b1);

    // Single entry popped, then empty
    cycle(1'b1, 64'h403C, 1'b1, 1'b0);
    check_val("one_vld", 64'(iq_vld_o), 64'h1);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_val("one_empty", 64'(iq_vld_o), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);

    // Bring wptr to 24, drain, then a full line wraps across the end
    cycle(1'b1, 64'h5000, 1'b0, 1'b0);
    cycle(1'b1, 64'h5060, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_val("wrap_pre_empty", 64'(iq_vld_o), 64'd0);
    cycle(1'b1, 64'h6000, 1'b1, 1'b0);
    check_val("wrap_pc0", iq_pc_o[63:0], 64'h6000);
    repeat (9) cycle(1'b0, 64'd0, 1'b0, 1'b0);

    // Flush coincident with write and pop at count 20
    cycle(1'b0, 64'd0, 1'b1, 1'b1);
    cycle(1'b1, 64'h7000, 1'b1, 1'b0);
    cycle(1'b1, 64'h7030, 1'b1, 1'b0);
    cycle(1'b1, 64'h8000, 1'b0, 1'b1);
    check_val("flush_vld", 64'(iq_vld_o), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);

    // Reset asserted while a write is being offered
    cycle(1'b1, 64'h9000, 1'b1, 1'b0);
    icache_valid_i = 1'b1;
    icache_pc_i    = 64'hA000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    full_exp = 0;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    icache_valid_i = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
